// File: rtl/stack_cmd_pkg.sv
// Shared opcodes, error codes and per-opcode depth rules for the stack command issuer.
package stack_cmd_pkg;

   localparam logic [2:0] OP_PUSH = 3'b101;
   localparam logic [2:0] OP_POP  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b110;
   localparam logic [2:0] OP_SUB  = 3'b010;

   localparam logic [1:0] ERR_NONE  = 2'd0;
   localparam logic [1:0] ERR_UNDER = 2'd1;
   localparam logic [1:0] ERR_OVER  = 2'd2;
   localparam logic [1:0] ERR_RSVD  = 2'd3;

   // True for any opcode the stack unit does not implement.
   function automatic logic op_reserved(input logic [2:0] op);
      return !(op == OP_PUSH || op == OP_POP || op == OP_ADD || op == OP_SUB);
   endfunction

   // Minimum stack depth the opcode needs before it may issue.
   function automatic logic [1:0] op_need(input logic [2:0] op);
      case (op)
         OP_POP:          return 2'd1;
         OP_ADD, OP_SUB:  return 2'd2;
         default:         return 2'd0;
      endcase
   endfunction

   // Net change of stack depth once the opcode has issued.
   function automatic logic signed [1:0] op_net(input logic [2:0] op);
      case (op)
         OP_PUSH:                 return 2'sd1;
         OP_POP, OP_ADD, OP_SUB:  return -2'sd1;
         default:                 return 2'sd0;
      endcase
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small count-based FIFO holding {opcode, operand} host commands.
// Head entry is read combinationally so the issue stage can decide in the same cycle.
module cmd_fifo #(
   parameter int W     = 11,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_en,
   output logic [W-1:0] rd_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          wr_fire;
   logic          rd_fire;

   // Full/empty come only from the registered count, so a pop never frees a slot combinationally.
   assign full    = (count_reg == CW'(DEPTH));
   assign empty   = (count_reg == '0);
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign rd_data = mem[rd_ptr_reg];

   // Storage write at the tail; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (wr_fire) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (rd_fire) rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({wr_fire, rd_fire})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/stack_cmd_issuer.sv
// Buffers host commands, checks each against a shadow stack depth and issues
// legal ones to the stack unit as a one-cycle strobe; illegal ones are dropped and flagged.
module stack_cmd_issuer
   import stack_cmd_pkg::*;
#(
   parameter int DW          = 8,
   parameter int FIFO_DEPTH  = 4,
   parameter int STACK_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               cmd_valid,
   output logic                               cmd_ready,
   input  logic [2:0]                         cmd_op,
   input  logic [DW-1:0]                      cmd_data,
   input  logic                               stall,
   output logic [DW-1:0]                      in,
   output logic [2:0]                         op,
   output logic                               apply,
   output logic                               err,
   output logic [1:0]                         err_code,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   depth
);

   localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic [DW+2:0]      head;
   logic [2:0]         head_op;
   logic [DW-1:0]      head_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic               issue_go;
   logic [1:0]         head_err;
   logic [DEPTH_W-1:0] depth_reg;
   logic [DEPTH_W-1:0] depth_next;
   logic [DW-1:0]      in_reg;
   logic [2:0]         op_reg;
   logic               apply_reg;
   logic               err_reg;
   logic [1:0]         err_code_reg;

   assign cmd_ready = !fifo_full;
   assign issue_go  = !fifo_empty && !stall;
   assign head_op   = head[DW+2:DW];
   assign head_data = head[DW-1:0];

   cmd_fifo #(
      .W     (DW + 3),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cmd_valid),
      .wr_data ({cmd_op, cmd_data}),
      .rd_en   (issue_go),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Legality of the head command against the registered shadow depth.
   always_comb begin
      head_err = ERR_NONE;
      if (op_reserved(head_op)) begin
         head_err = ERR_RSVD;
      end else if (depth_reg < DEPTH_W'(op_need(head_op))) begin
         head_err = ERR_UNDER;
      end else if (head_op == OP_PUSH && depth_reg == DEPTH_W'(STACK_DEPTH)) begin
         head_err = ERR_OVER;
      end
   end

   // Shadow depth moves only when a legal command issues, so it stays within 0..STACK_DEPTH.
   always_comb begin
      depth_next = depth_reg;
      if (issue_go && head_err == ERR_NONE) begin
         if (op_net(head_op) == 2'sd1) begin
            depth_next = depth_reg + DEPTH_W'(1);
         end else if (op_net(head_op) == -2'sd1) begin
            depth_next = depth_reg - DEPTH_W'(1);
         end
      end
   end

   // Registered issue stage: strobes, held operand/opcode, sticky error code and depth.
   always_ff @(posedge clk) begin
      if (rst) begin
         apply_reg    <= 1'b0;
         err_reg      <= 1'b0;
         err_code_reg <= ERR_NONE;
         op_reg       <= '0;
         in_reg       <= '0;
         depth_reg    <= '0;
      end else begin
         apply_reg <= 1'b0;
         err_reg   <= 1'b0;
         depth_reg <= depth_next;
         if (issue_go) begin
            if (head_err == ERR_NONE) begin
               apply_reg <= 1'b1;
               op_reg    <= head_op;
               in_reg    <= (head_op == OP_PUSH) ? head_data : '0;
            end else begin
               err_reg      <= 1'b1;
               err_code_reg <= head_err;
            end
         end
      end
   end

   assign apply    = apply_reg;
   assign err      = err_reg;
   assign err_code = err_code_reg;
   assign op       = op_reg;
   assign in       = in_reg;
   assign depth    = depth_reg;

endmodule

// File: tb/tb_stack_cmd_issuer.sv
// Directed self-checking bench for stack_cmd_issuer (DW=8, FIFO_DEPTH=4, STACK_DEPTH=8).
module tb_stack_cmd_issuer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [7:0] cmd_data;
   logic       stall;
   logic [7:0] dut_in;
   logic [2:0] dut_op;
   logic       apply;
   logic       err;
   logic [1:0] err_code;
   logic [3:0] depth;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   stack_cmd_issuer #(.DW(8), .FIFO_DEPTH(4), .STACK_DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .stall     (stall),
      .in        (dut_in),
      .op        (dut_op),
      .apply     (apply),
      .err       (err),
      .err_code  (err_code),
      .depth     (depth)
   );

   // Advance one edge; inputs change and outputs are sampled 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b0; cmd_data = 8'h0; stall = 1'b0;
      tick(); tick();
      rst = 1'b0;
   endtask

   // Present one command for exactly one edge (FIFO assumed to have room).
   task automatic offer(input logic [2:0] o, input logic [7:0] d);
      cmd_valid = 1'b1; cmd_op = o; cmd_data = d;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      tests_run++; if (apply !== 1'b0) begin tests_failed++; $display("FAIL reset_apply got=%b exp=0", apply); end
      tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err got=%b exp=0", err); end
      tests_run++; if (err_code !== 2'd0) begin tests_failed++; $display("FAIL reset_err_code got=%0d exp=0", err_code); end
      tests_run++; if ({dut_op, dut_in} !== 11'h0) begin tests_failed++; $display("FAIL reset_op_in got=%h/%h exp=0/0", dut_op, dut_in); end
      tests_run++; if (depth !== 4'd0) begin tests_failed++; $display("FAIL reset_depth got=%0d exp=0", depth); end
      tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
      $display("[TB] test_reset done");
   endtask

   task automatic test_push_burst();
      logic [7:0] vals [3] = '{8'd1, 8'd2, 8'd9};
      do_reset();
      cmd_valid = 1'b1; cmd_op = 3'b101; cmd_data = vals[0];
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) cmd_data = vals[i+1]; else cmd_valid = 1'b0;
         tick();
         tests_run++;
         if (apply !== 1'b1 || dut_in !== vals[i] || dut_op !== 3'b101) begin
            tests_failed++;
            $display("FAIL burst_issue%0d got apply=%b in=%0d op=%b exp apply=1 in=%0d op=101", i, apply, dut_in, dut_op, vals[i]);
         end
      end
      tests_run++; if (depth !== 4'd3) begin tests_failed++; $display("FAIL burst_depth got=%0d exp=3", depth); end
      tick();
      tests_run++; if (apply !== 1'b0 || dut_in !== 8'd9) begin tests_failed++; $display("FAIL burst_idle got apply=%b in=%0d exp apply=0 in=9", apply, dut_in); end
      $display("[TB] test_push_burst done");
   endtask

   task automatic test_pop_underflow();
      do_reset();
      offer(3'b000, 8'h55);
      tick();
      tests_run++;
      if (apply !== 1'b0 || err !== 1'b1 || err_code !== 2'd1 || depth !== 4'd0) begin
         tests_failed++;
         $display("FAIL pop_empty got apply=%b err=%b code=%0d depth=%0d exp 0/1/1/0", apply, err, err_code, depth);
      end
      tick();
      tests_run++;
      if (err !== 1'b0 || err_code !== 2'd1) begin
         tests_failed++;
         $display("FAIL pop_err_hold got err=%b code=%0d exp err=0 code=1", err, err_code);
      end
      $display("[TB] test_pop_underflow done");
   endtask

   task automatic test_add_sequence();
      do_reset();
      offer(3'b101, 8'd5);
      tick();                                 // depth -> 1
      offer(3'b110, 8'd0);
      tick();
      tests_run++;
      if (err !== 1'b1 || err_code !== 2'd1 || apply !== 1'b0 || depth !== 4'd1) begin
         tests_failed++;
         $display("FAIL add_under got err=%b code=%0d apply=%b depth=%0d exp 1/1/0/1", err, err_code, apply, depth);
      end
      offer(3'b101, 8'd4);
      offer(3'b101, 8'd6);                    // PUSH 4 issues on this edge
      offer(3'b110, 8'hAA);                   // PUSH 6 issues on this edge
      tests_run++;
      if (apply !== 1'b1 || dut_in !== 8'd6 || depth !== 4'd3) begin
         tests_failed++;
         $display("FAIL add_push6 got apply=%b in=%0d depth=%0d exp 1/6/3", apply, dut_in, depth);
      end
      tick();                                 // ADD issues
      tests_run++;
      if (apply !== 1'b1 || dut_op !== 3'b110 || dut_in !== 8'd0 || depth !== 4'd2 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL add_issue got apply=%b op=%b in=%0d depth=%0d err=%b exp 1/110/0/2/0", apply, dut_op, dut_in, depth, err);
      end
      $display("[TB] test_add_sequence done");
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         offer(3'b101, 8'(8'd10 + i));
         if (i >= 1) begin
            tests_run++;
            if (apply !== 1'b1 || dut_in !== 8'(8'd10 + i - 1) || depth !== 4'(i)) begin
               tests_failed++;
               $display("FAIL ovf_push%0d got apply=%b in=%0d depth=%0d exp 1/%0d/%0d", i - 1, apply, dut_in, depth, 10 + i - 1, i);
            end
         end
      end
      tick();
      tests_run++;
      if (apply !== 1'b0 || err !== 1'b1 || err_code !== 2'd2 || depth !== 4'd8) begin
         tests_failed++;
         $display("FAIL ovf_ninth got apply=%b err=%b code=%0d depth=%0d exp 0/1/2/8", apply, err, err_code, depth);
      end
      $display("[TB] test_overflow done");
   endtask

   task automatic test_stall();
      int accepted = 0;
      do_reset();
      stall = 1'b1;
      cmd_op = 3'b101;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_data = 8'(8'd21 + accepted);
         #1;
         if (cmd_ready) accepted++;
         tick();
      end
      cmd_valid = 1'b0;
      tests_run++; if (accepted !== 4) begin tests_failed++; $display("FAIL stall_accepted got=%0d exp=4", accepted); end
      tests_run++; if (cmd_ready !== 1'b0 || apply !== 1'b0) begin tests_failed++; $display("FAIL stall_full got ready=%b apply=%b exp 0/0", cmd_ready, apply); end
      stall = 1'b0;
      #1;
      tests_run++; if (cmd_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_no_bypass got ready=%b exp=0", cmd_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         tests_run++;
         if (apply !== 1'b1 || dut_in !== 8'(8'd21 + i) || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_drain%0d got apply=%b in=%0d ready=%b exp 1/%0d/1", i, apply, dut_in, cmd_ready, 21 + i);
         end
      end
      tick();
      tests_run++; if (apply !== 1'b0 || depth !== 4'd4) begin tests_failed++; $display("FAIL stall_end got apply=%b depth=%0d exp 0/4", apply, depth); end
      $display("[TB] test_stall done");
   endtask

   task automatic test_reserved_and_reset();
      do_reset();
      offer(3'b111, 8'h33);
      tick();
      tests_run++;
      if (err !== 1'b1 || err_code !== 2'd3 || apply !== 1'b0) begin
         tests_failed++;
         $display("FAIL rsvd got err=%b code=%0d apply=%b exp 1/3/0", err, err_code, apply);
      end
      offer(3'b101, 8'd7);
      tick();                                 // depth -> 1
      stall = 1'b1;
      offer(3'b101, 8'd8);
      offer(3'b101, 8'd9);
      rst = 1'b1;
      tick();
      rst = 1'b0; stall = 1'b0;
      tests_run++;
      if (depth !== 4'd0 || apply !== 1'b0 || cmd_ready !== 1'b1 || err_code !== 2'd0) begin
         tests_failed++;
         $display("FAIL midrst got depth=%0d apply=%b ready=%b code=%0d exp 0/0/1/0", depth, apply, cmd_ready, err_code);
      end
      tick(); tick();
      tests_run++;
      if (apply !== 1'b0 || err !== 1'b0 || depth !== 4'd0) begin
         tests_failed++;
         $display("FAIL midrst_flushed got apply=%b err=%b depth=%0d exp 0/0/0", apply, err, depth);
      end
      $display("[TB] test_reserved_and_reset done");
   endtask

   initial begin
      test_reset();
      test_push_burst();
      test_pop_underflow();
      test_add_sequence();
      test_overflow();
      test_stall();
      test_reserved_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
